// File: rtl/external_input.sv
// external_input: board DIP-switch word capture with ENTER-button debounce.
// The operator sets the switches and presses ENTER. The debounced press latches
// the synchronised switch word into a holding register. The CPU then reads that
// word, or a status word {overrun, word_valid, button_down}, through a one-cycle
// read strobe.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_UP       | button released and stable
// ST_CHK_DOWN | button seen pressed, waiting for it to stay pressed
// ST_DOWN     | button pressed and stable (capture already done)
// ST_CHK_UP   | button seen released, waiting for it to stay released
module external_input #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] dip_sw,
   input  logic        btn_enter,
   input  logic        read_req,
   input  logic        read_sel,
   output logic [15:0] output_data,
   output logic        word_valid,
   output logic        overrun
);

   typedef enum logic [1:0] {
      ST_UP       = 2'd0,
      ST_CHK_DOWN = 2'd1,
      ST_DOWN     = 2'd2,
      ST_CHK_UP   = 2'd3
   } state_t;

   // Terminal count: the counter value reached on the last stable sample of
   // a check window. The window starts with the sample that left UP or DOWN,
   // so a level must be seen for DEBOUNCE_CYCLES consecutive clocks.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic        btn_meta;
   logic        btn_s;
   logic [15:0] dip_meta;
   logic [15:0] dip_s;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic             capture;
   logic             btn_down;

   logic [15:0] hold_reg;
   logic        data_rd;
   logic        stat_rd;

   assign cnt_inc  = cnt + CNT_W'(1);
   assign btn_down = (state == ST_DOWN);
   assign data_rd  = read_req & ~read_sel;
   assign stat_rd  = read_req &  read_sel;

   // Two-flop synchronisers for the raw board inputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
         dip_meta <= '0;
         dip_s    <= '0;
      end else begin
         btn_meta <= btn_enter;
         btn_s    <= btn_meta;
         dip_meta <= dip_sw;
         dip_s    <= dip_meta;
      end
   end

   // Debounce state and stability counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_UP;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Debounce next-state logic. The capture strobe fires only on CHK_DOWN->DOWN,
   // so a held button produces exactly one capture.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      case (state)
         ST_UP: begin
            if (btn_s) begin
               state_nxt = ST_CHK_DOWN;
               cnt_nxt   = '0;
            end
         end
         ST_CHK_DOWN: begin
            if (!btn_s) begin
               state_nxt = ST_UP;
            end else begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == CNT_LAST) begin
                  state_nxt = ST_DOWN;
                  capture   = 1'b1;
               end
            end
         end
         ST_DOWN: begin
            if (!btn_s) begin
               state_nxt = ST_CHK_UP;
               cnt_nxt   = '0;
            end
         end
         ST_CHK_UP: begin
            if (btn_s) begin
               state_nxt = ST_DOWN;
            end else begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == CNT_LAST) begin
                  state_nxt = ST_UP;
               end
            end
         end
         default: begin
            state_nxt = ST_UP;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Holding register, flags and CPU read port. The status word reflects the
   // flags before this edge. A capture beats a read-side clear of the same
   // flag. A data read that coincides with a capture consumes the old word,
   // so that capture is not an overrun.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_reg    <= '0;
         word_valid  <= 1'b0;
         overrun     <= 1'b0;
         output_data <= '0;
      end else begin
         if (read_req) begin
            output_data <= read_sel ? {13'd0, overrun, word_valid, btn_down}
                                    : hold_reg;
         end
         if (capture) begin
            hold_reg <= dip_s;
         end
         if (capture) begin
            word_valid <= 1'b1;
         end else if (data_rd) begin
            word_valid <= 1'b0;
         end
         if (capture && word_valid && !data_rd) begin
            overrun <= 1'b1;
         end else if (stat_rd) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_external_input.sv
// Self-checking bench for external_input with a short debounce window.
module tb_external_input;

   localparam int DB = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] dip_sw;
   logic        btn_enter;
   logic        read_req;
   logic        read_sel;
   logic [15:0] output_data;
   logic        word_valid;
   logic        overrun;

   int n_cmp = 0;
   int n_err = 0;

   external_input #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .dip_sw      (dip_sw),
      .btn_enter   (btn_enter),
      .read_req    (read_req),
      .read_sel    (read_sel),
      .output_data (output_data),
      .word_valid  (word_valid),
      .overrun     (overrun)
   );

   always #5 clock = ~clock;

   // Reference model. The button's debounced level flips after it has
   // disagreed with that level for DB consecutive synchronised samples.
   // "Pressed and settled" means the level is 1 with no disagreement pending.
   logic        m_b1 = 0, m_b2 = 0;
   logic [15:0] m_d1 = 0, m_d2 = 0;
   logic        m_deb = 0;
   int          m_run = 0;
   logic [15:0] m_hold = 0, m_out = 0;
   logic        m_val = 0, m_ovr = 0;
   logic        m_cap, m_settled, m_drd, m_srd;

   always @(posedge clock) begin
      if (reset) begin
         m_b1 = 0; m_b2 = 0; m_d1 = 0; m_d2 = 0; m_deb = 0; m_run = 0;
         m_hold = 0; m_out = 0; m_val = 0; m_ovr = 0;
      end else begin
         m_cap     = 0;
         m_settled = m_deb && (m_run == 0);
         if (m_b2 != m_deb) begin
            if (m_run + 1 == DB) begin
               m_deb = ~m_deb;
               m_run = 0;
               m_cap = m_deb;
            end else begin
               m_run = m_run + 1;
            end
         end else begin
            m_run = 0;
         end
         m_drd = read_req && !read_sel;
         m_srd = read_req && read_sel;
         if (read_req) m_out = read_sel ? {13'd0, m_ovr, m_val, m_settled} : m_hold;
         if (m_cap && m_val && !m_drd) m_ovr = 1;
         else if (m_srd) m_ovr = 0;
         if (m_cap) m_val = 1;
         else if (m_drd) m_val = 0;
         if (m_cap) m_hold = m_d2;
         m_b2 = m_b1; m_b1 = btn_enter;
         m_d2 = m_d1; m_d1 = dip_sw;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic rd(input logic sel);
      read_req = 1'b1;
      read_sel = sel;
      tick();
      read_req = 1'b0;
      read_sel = 1'b0;
   endtask

   task automatic press_release(input logic [15:0] word, input int hold);
      dip_sw    = word;
      btn_enter = 1'b1;
      tick(hold);
      btn_enter = 1'b0;
      tick(10);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      dip_sw = 16'hFFFF;
      tick(2);
      reset = 1'b0;
      n_cmp++;
      if (output_data !== 16'h0000) begin
         $display("FAIL reset_data: got %h want 0000", output_data); n_err++;
      end
      n_cmp++;
      if (word_valid !== 1'b0) begin
         $display("FAIL reset_valid: got %b want 0", word_valid); n_err++;
      end
      n_cmp++;
      if (overrun !== 1'b0) begin
         $display("FAIL reset_overrun: got %b want 0", overrun); n_err++;
      end
   endtask

   task automatic test_capture_read();
      dip_sw    = 16'hA5C3;
      btn_enter = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 5) begin
            n_cmp++;
            if (word_valid !== 1'b0) begin
               $display("FAIL capture_early: got %b want 0 at clk 5", word_valid); n_err++;
            end
         end
         if (i == 6) begin
            n_cmp++;
            if (word_valid !== 1'b1) begin
               $display("FAIL capture_latency: got %b want 1 at clk 6", word_valid); n_err++;
            end
         end
      end
      btn_enter = 1'b0;
      tick(10);
      rd(1'b0);
      n_cmp++;
      if (output_data !== 16'hA5C3) begin
         $display("FAIL capture_data: got %h want a5c3", output_data); n_err++;
      end
      n_cmp++;
      if (word_valid !== 1'b0) begin
         $display("FAIL capture_valid_clr: got %b want 0", word_valid); n_err++;
      end
   endtask

   task automatic test_bounce();
      dip_sw = 16'h5A5A;
      btn_enter = 1'b1; tick();
      btn_enter = 1'b0; tick();
      btn_enter = 1'b1; tick();
      btn_enter = 1'b0; tick(12);
      n_cmp++;
      if (word_valid !== 1'b0) begin
         $display("FAIL bounce_valid: got %b want 0", word_valid); n_err++;
      end
      rd(1'b1);
      n_cmp++;
      if (output_data !== 16'h0000) begin
         $display("FAIL bounce_status: got %h want 0000", output_data); n_err++;
      end
   endtask

   task automatic test_overrun();
      press_release(16'h0001, 8);
      press_release(16'h0002, 8);
      n_cmp++;
      if (overrun !== 1'b1) begin
         $display("FAIL overrun_set: got %b want 1", overrun); n_err++;
      end
      rd(1'b1);
      n_cmp++;
      if (output_data !== 16'h0006) begin
         $display("FAIL overrun_status: got %h want 0006", output_data); n_err++;
      end
      n_cmp++;
      if (overrun !== 1'b0 || word_valid !== 1'b1) begin
         $display("FAIL overrun_clr: got ovr=%b val=%b want ovr=0 val=1", overrun, word_valid);
         n_err++;
      end
      rd(1'b0);
      n_cmp++;
      if (output_data !== 16'h0002) begin
         $display("FAIL overrun_data: got %h want 0002", output_data); n_err++;
      end
   endtask

   task automatic test_back_to_back();
      press_release(16'h1111, 8);
      dip_sw    = 16'h2222;
      btn_enter = 1'b1;
      tick(5);
      read_req = 1'b1;
      read_sel = 1'b0;
      tick();
      read_req = 1'b0;
      n_cmp++;
      if (output_data !== 16'h1111) begin
         $display("FAIL coincident_data: got %h want 1111", output_data); n_err++;
      end
      n_cmp++;
      if (word_valid !== 1'b1 || overrun !== 1'b0) begin
         $display("FAIL coincident_flags: got val=%b ovr=%b want val=1 ovr=0", word_valid, overrun);
         n_err++;
      end
      tick(3);
      btn_enter = 1'b0;
      tick(10);
      rd(1'b0);
      n_cmp++;
      if (output_data !== 16'h2222) begin
         $display("FAIL coincident_next: got %h want 2222", output_data); n_err++;
      end
   endtask

   task automatic test_reset_mid_debounce();
      dip_sw    = 16'h3333;
      btn_enter = 1'b1;
      tick(4);
      reset     = 1'b1;
      btn_enter = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(12);
      n_cmp++;
      if (word_valid !== 1'b0 || output_data !== 16'h0000) begin
         $display("FAIL midreset: got val=%b data=%h want val=0 data=0000", word_valid, output_data);
         n_err++;
      end
      dip_sw    = 16'h4444;
      btn_enter = 1'b1;
      tick(6);
      n_cmp++;
      if (word_valid !== 1'b1) begin
         $display("FAIL midreset_fresh: got %b want 1", word_valid); n_err++;
      end
      btn_enter = 1'b0;
      tick(10);
      rd(1'b0);
      n_cmp++;
      if (output_data !== 16'h4444) begin
         $display("FAIL midreset_data: got %h want 4444", output_data); n_err++;
      end
   endtask

   task automatic test_random();
      int hold_left;
      hold_left = 0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (hold_left == 0) begin
            btn_enter = 1'($urandom_range(0, 1));
            hold_left = $urandom_range(1, 8);
         end
         hold_left--;
         dip_sw   = 16'($urandom);
         read_req = ($urandom_range(0, 5) == 0);
         read_sel = 1'($urandom_range(0, 1));
         reset    = ($urandom_range(0, 199) == 0);
         tick();
         n_cmp++;
         if (output_data !== m_out || word_valid !== m_val || overrun !== m_ovr) begin
            $display("FAIL random cyc %0d: got data=%h val=%b ovr=%b want data=%h val=%b ovr=%b",
                     i, output_data, word_valid, overrun, m_out, m_val, m_ovr);
            n_err++;
         end
      end
      reset = 1'b0; read_req = 1'b0; read_sel = 1'b0; btn_enter = 1'b0;
   endtask

   initial begin
      reset = 1'b1; dip_sw = '0; btn_enter = 1'b0; read_req = 1'b0; read_sel = 1'b0;
      @(negedge clock);
      test_reset();
      test_capture_read();
      test_bounce();
      test_overrun();
      test_back_to_back();
      test_reset_mid_debounce();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
